// File: rtl/fft_frame_sched.sv
// Frame scheduler: buffers a 32-bit sample stream in a 256-entry ring and replays
// overlapping 256-sample frames (programmable hop) into win_fft. Optional irq: FFT_SCHED_IRQ_EN.
module fft_frame_sched (
  input  logic        hclk,
  input  logic        rst_n,
  input  logic        cfg_enable,
  input  logic [7:0]  cfg_hop,
  input  logic        cfg_win,
  input  logic [7:0]  cfg_n_need,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] f_data,
  output logic        f_valid,
  input  logic        f_ready,
  output logic        f_win,
  output logic [7:0]  f_n_need,
  input  logic        f_frame_done,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        irq,
  input  logic        irq_clr
);

  localparam int unsigned DEPTH = 256;
  localparam logic [8:0]  FULL  = 9'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, SEND, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [7:0]  wr_ptr_q, wr_ptr_d;
  logic [7:0]  start_ptr_q, start_ptr_d;
  logic [7:0]  rd_cnt_q, rd_cnt_d;
  logic [7:0]  hop_lat_q, hop_lat_d;
  logic [8:0]  occ_q, occ_d;
  logic [31:0] f_data_q, f_data_d;
  logic        f_valid_q, f_valid_d;
  logic        f_win_q, f_win_d;
  logic [7:0]  f_n_need_q, f_n_need_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [8:0]  hop_eff;
  logic [7:0]  rd_idx;
  logic        wr_en;
  logic        frame_fin;

  assign s_ready   = ((state_q == FILL) || (state_q == SEND) || (state_q == DRAIN)) && (occ_q < FULL);
  assign wr_en     = s_valid & s_ready;
  assign hop_eff   = (hop_lat_q == '0) ? FULL : {1'b0, hop_lat_q};
  assign busy      = (state_q != IDLE);
  assign f_data    = f_data_q;
  assign f_valid   = f_valid_q;
  assign f_win     = f_win_q;
  assign f_n_need  = f_n_need_q;
  assign frame_cnt = frame_cnt_q;

  always_ff @(posedge hclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s_data;
  end

  // Output register is preloaded with the first beat on the FILL->SEND edge and
  // refilled with the following beat on every handshake.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    hop_lat_d   = hop_lat_q;
    occ_d       = occ_q;
    f_data_d    = f_data_q;
    f_valid_d   = f_valid_q;
    f_win_d     = f_win_q;
    f_n_need_d  = f_n_need_q;
    frame_cnt_d = frame_cnt_q;
    frame_fin   = 1'b0;
    rd_idx      = start_ptr_q + rd_cnt_q + 8'd1;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 8'd1;
      occ_d    = occ_q + 9'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_enable) state_d = FILL;
      end
      FILL: begin
        if (!cfg_enable) begin
          state_d = IDLE;
        end else if (occ_q == FULL) begin
          hop_lat_d  = cfg_hop;
          f_win_d    = cfg_win;
          f_n_need_d = cfg_n_need;
          rd_cnt_d   = '0;
          f_data_d   = mem_q[start_ptr_q];
          f_valid_d  = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (f_valid_q && f_ready) begin
          rd_cnt_d = rd_cnt_q + 8'd1;
          if (rd_cnt_q == 8'hFF) begin
            f_valid_d = 1'b0;
            state_d   = DRAIN;
          end else begin
            f_data_d = mem_q[rd_idx];
          end
        end
      end
      DRAIN: begin
        if (f_frame_done) begin
          frame_fin   = 1'b1;
          start_ptr_d = start_ptr_q + hop_eff[7:0];
          occ_d       = occ_d - hop_eff;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = cfg_enable ? FILL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      occ_d       = '0;
      wr_ptr_d    = '0;
      start_ptr_d = '0;
      rd_cnt_d    = '0;
    end
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      rd_cnt_q    <= '0;
      hop_lat_q   <= '0;
      occ_q       <= '0;
      f_data_q    <= '0;
      f_valid_q   <= 1'b0;
      f_win_q     <= 1'b0;
      f_n_need_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      hop_lat_q   <= hop_lat_d;
      occ_q       <= occ_d;
      f_data_q    <= f_data_d;
      f_valid_q   <= f_valid_d;
      f_win_q     <= f_win_d;
      f_n_need_q  <= f_n_need_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef FFT_SCHED_IRQ_EN
  logic irq_q, irq_d;

  // A completion wins over a coincident clear.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr)   irq_d = 1'b0;
    if (frame_fin) irq_d = 1'b1;
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed self-checking bench for fft_frame_sched: ramp streams with hand-derived
// frame contents, backpressure, enable drop, reset mid-frame and irq behaviour.
module tb_fft_frame_sched;

`ifdef FFT_SCHED_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        rst_n;
  logic        cfg_enable;
  logic [7:0]  cfg_hop;
  logic        cfg_win;
  logic [7:0]  cfg_n_need;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] f_data;
  logic        f_valid;
  logic        f_ready;
  logic        f_win;
  logic [7:0]  f_n_need;
  logic        f_frame_done;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        irq;
  logic        irq_clr;

  fft_frame_sched dut (
    .hclk(hclk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_hop(cfg_hop),
    .cfg_win(cfg_win), .cfg_n_need(cfg_n_need), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .f_win(f_win), .f_n_need(f_n_need), .f_frame_done(f_frame_done), .busy(busy),
    .frame_cnt(frame_cnt), .irq(irq), .irq_clr(irq_clr)
  );

  always #5 hclk = ~hclk;

  int total = 0;
  int bad   = 0;

  int          next_sample, max_samples, occ_m, hop_m, drop_at_beat;
  bit          rnd_ready, toggle_cfg, clr_with_done, timeout;
  logic        base_win;
  logic [7:0]  base_nn;
  logic [31:0] q_data[$];
  logic        q_win[$];
  logic [7:0]  q_nn[$];
  int          stall_err, sready_err, first_hs_cyc, last_hs_cyc;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_enable = 1'b0; cfg_hop = '0; cfg_win = 1'b0; cfg_n_need = '0;
    s_data = '0; s_valid = 1'b0; f_ready = 1'b0; f_frame_done = 1'b0; irq_clr = 1'b0;
    next_sample = 0; max_samples = 0; occ_m = 0; hop_m = 256; drop_at_beat = -1;
    rnd_ready = 0; toggle_cfg = 0; clr_with_done = 0;
    repeat (3) @(posedge hclk);
    #1;
    rst_n = 1'b1;
  endtask

  // Stimulus engine: ramp producer, consumer capturing beats, frame_done 10 cycles
  // after every 256th beat; returns once nframes completions were consumed.
  task automatic run_frames(input int nframes);
    int frames, cd, cyc, beats;
    bit done_now, done_prev, stall_prev;
    logic [31:0] stall_data;
    frames = 0; cd = 0; cyc = 0; beats = 0;
    done_prev = 0; stall_prev = 0; stall_data = '0; timeout = 0;
    stall_err = 0; sready_err = 0; first_hs_cyc = 0; last_hs_cyc = 0;
    q_data.delete(); q_win.delete(); q_nn.delete();
    while (frames < nframes) begin
      tick();
      cyc++;
      if (done_prev) begin
        frames++;
        occ_m -= hop_m;
      end
      if (frames >= nframes) break;
      if (cyc > 6000) begin
        timeout = 1;
        break;
      end
      done_now = 0;
      if (cd > 0) begin
        cd--;
        done_now = (cd == 0);
      end
      f_frame_done = done_now;
      irq_clr = done_now & clr_with_done;
      done_prev = done_now;
      s_valid = (next_sample < max_samples);
      s_data = next_sample;
      f_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (toggle_cfg) begin
        cfg_win = f_valid ? ~base_win : base_win;
        cfg_n_need = f_valid ? ~base_nn : base_nn;
      end
      if (drop_at_beat >= 0 && beats >= drop_at_beat) cfg_enable = 1'b0;
      @(negedge hclk);
      if (stall_prev && (f_valid !== 1'b1 || f_data !== stall_data)) stall_err++;
      if (occ_m == 256 && s_ready === 1'b1) sready_err++;
      if (s_valid && s_ready) begin
        next_sample++;
        occ_m++;
      end
      if (f_valid && f_ready) begin
        q_data.push_back(f_data);
        q_win.push_back(f_win);
        q_nn.push_back(f_n_need);
        beats++;
        if (beats == 1) first_hs_cyc = cyc;
        if (beats == 256) last_hs_cyc = cyc;
        if (beats % 256 == 0) cd = 10;
      end
      stall_prev = f_valid && !f_ready;
      stall_data = f_data;
    end
    f_frame_done = 1'b0; irq_clr = 1'b0; s_valid = 1'b0; f_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL rst_s_ready got=%0b exp=0", s_ready); end
    total++; if (f_valid !== 1'b0)   begin bad++; $display("FAIL rst_f_valid got=%0b exp=0", f_valid); end
    total++; if (f_data !== 32'd0)   begin bad++; $display("FAIL rst_f_data got=%0h exp=0", f_data); end
    total++; if (f_win !== 1'b0)     begin bad++; $display("FAIL rst_f_win got=%0b exp=0", f_win); end
    total++; if (f_n_need !== 8'd0)  begin bad++; $display("FAIL rst_f_n_need got=%0h exp=0", f_n_need); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
    total++; if (irq !== 1'b0)       begin bad++; $display("FAIL rst_irq got=%0b exp=0", irq); end
    cfg_enable = 1'b1;
    tick();
    f_frame_done = 1'b1;
    tick();
    f_frame_done = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fill_busy got=%0b exp=1", busy); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fill_s_ready got=%0b exp=1", s_ready); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL stray_done_cnt got=%0d exp=0", frame_cnt); end
  endtask

  task automatic test_hop0();
    int nerr;
    logic [31:0] exp;
    do_reset();
    cfg_hop = 8'd0; cfg_win = 1'b1; cfg_n_need = 8'd40; cfg_enable = 1'b1;
    hop_m = 256; max_samples = 512;
    run_frames(2);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL hop0_timeout got=%0b exp=0", timeout); end
    total++; if (q_data.size() != 512) begin bad++; $display("FAIL hop0_beats got=%0d exp=512", q_data.size()); end
    nerr = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      exp = 32'(i);
      total++;
      if (q_data[i] !== exp || q_win[i] !== 1'b1 || q_nn[i] !== 8'd40) begin
        bad++;
        if (nerr < 4) $display("FAIL hop0_beat[%0d] got=%0d/%0b/%0d exp=%0d/1/40", i, q_data[i], q_win[i], q_nn[i], exp);
        nerr++;
      end
    end
    total++; if (last_hs_cyc - first_hs_cyc != 255) begin bad++; $display("FAIL hop0_rate got=%0d exp=255", last_hs_cyc - first_hs_cyc); end
    total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL hop0_frame_cnt got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_hop128();
    int nerr;
    logic [31:0] exp;
    do_reset();
    cfg_hop = 8'd128; cfg_enable = 1'b1;
    hop_m = 128; max_samples = 512;
    run_frames(3);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL hop128_timeout got=%0b exp=0", timeout); end
    total++; if (q_data.size() != 768) begin bad++; $display("FAIL hop128_beats got=%0d exp=768", q_data.size()); end
    nerr = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      exp = 32'((i / 256) * 128 + (i % 256));
      total++;
      if (q_data[i] !== exp) begin
        bad++;
        if (nerr < 4) $display("FAIL hop128_beat[%0d] got=%0d exp=%0d", i, q_data[i], exp);
        nerr++;
      end
    end
    total++; if (sready_err != 0) begin bad++; $display("FAIL hop128_s_ready_full got=%0d exp=0", sready_err); end
    total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL hop128_frame_cnt got=%0d exp=3", frame_cnt); end
  endtask

  task automatic test_backpressure();
    int nerr;
    logic [31:0] exp;
    do_reset();
    cfg_hop = 8'd64; base_win = 1'b1; base_nn = 8'h5A;
    cfg_win = base_win; cfg_n_need = base_nn; cfg_enable = 1'b1;
    hop_m = 64; max_samples = 320; rnd_ready = 1; toggle_cfg = 1;
    run_frames(2);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL bp_timeout got=%0b exp=0", timeout); end
    total++; if (q_data.size() != 512) begin bad++; $display("FAIL bp_beats got=%0d exp=512", q_data.size()); end
    nerr = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      exp = 32'((i / 256) * 64 + (i % 256));
      total++;
      if (q_data[i] !== exp || q_win[i] !== 1'b1 || q_nn[i] !== 8'h5A) begin
        bad++;
        if (nerr < 4) $display("FAIL bp_beat[%0d] got=%0d/%0b/%0h exp=%0d/1/5a", i, q_data[i], q_win[i], q_nn[i], exp);
        nerr++;
      end
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
    total++; if (sready_err != 0) begin bad++; $display("FAIL bp_s_ready_full got=%0d exp=0", sready_err); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    cfg_hop = 8'd0; cfg_enable = 1'b1;
    hop_m = 256; max_samples = 300; drop_at_beat = 50;
    run_frames(1);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL drop_timeout got=%0b exp=0", timeout); end
    total++; if (q_data.size() != 256) begin bad++; $display("FAIL drop_beats got=%0d exp=256", q_data.size()); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL drop_frame_cnt got=%0d exp=1", frame_cnt); end
    s_valid = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%0b exp=0", busy); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL drop_s_ready got=%0b exp=0", s_ready); end
    s_valid = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    int acc, beats, guard;
    bit early, seen;
    do_reset();
    cfg_hop = 8'd0; cfg_win = 1'b1; cfg_n_need = 8'd7; cfg_enable = 1'b1; f_ready = 1'b1;
    acc = 0; beats = 0; guard = 0;
    while (beats < 100 && guard < 1000) begin
      tick();
      guard++;
      s_valid = (acc < 256);
      s_data = 32'(acc + 5000);
      @(negedge hclk);
      if (s_valid && s_ready) acc++;
      if (f_valid && f_ready) beats++;
    end
    total++; if (beats != 100) begin bad++; $display("FAIL rms_reach_send got=%0d exp=100", beats); end
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (f_valid !== 1'b0 || f_data !== 32'd0 || f_win !== 1'b0 || f_n_need !== 8'd0)
      begin bad++; $display("FAIL rms_f_outputs got=%0b/%0h/%0b/%0h exp=0/0/0/0", f_valid, f_data, f_win, f_n_need); end
    total++; if (s_ready !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0 || irq !== 1'b0)
      begin bad++; $display("FAIL rms_status got=%0b/%0b/%0d/%0b exp=0/0/0/0", s_ready, busy, frame_cnt, irq); end
    tick();
    rst_n = 1'b1;
    acc = 0; guard = 0; early = 0;
    while (acc < 255 && guard < 1000) begin
      tick();
      guard++;
      s_valid = 1'b1;
      s_data = 32'(acc + 1000);
      @(negedge hclk);
      if (s_ready) acc++;
      if (f_valid) early = 1;
    end
    tick();
    s_data = 32'd1255;
    @(negedge hclk);
    if (f_valid) early = 1;
    total++; if (early !== 1'b0) begin bad++; $display("FAIL rms_early_valid got=%0b exp=0", early); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rms_last_slot got=%0b exp=1", s_ready); end
    tick();
    s_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge hclk);
      if (f_valid) seen = 1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rms_valid_rise got=%0b exp=1", seen); end
    total++; if (f_data !== 32'd1000) begin bad++; $display("FAIL rms_first_beat got=%0d exp=1000", f_data); end
    f_ready = 1'b0;
  endtask

  task automatic test_irq();
    do_reset();
    cfg_hop = 8'd0; cfg_enable = 1'b1;
    hop_m = 256; max_samples = 256;
    run_frames(1);
    total++; if (irq !== IRQ_EN) begin bad++; $display("FAIL irq_set got=%0b exp=%0b", irq, IRQ_EN); end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%0b exp=0", irq); end
    max_samples = 512; clr_with_done = 1;
    run_frames(1);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL irq_timeout got=%0b exp=0", timeout); end
    total++; if (irq !== IRQ_EN) begin bad++; $display("FAIL irq_set_vs_clr got=%0b exp=%0b", irq, IRQ_EN); end
    total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL irq_frame_cnt got=%0d exp=2", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_hop0();
    test_hop128();
    test_backpressure();
    test_enable_drop();
    test_reset_mid_send();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
